// File: rtl/pa_fpu.sv
// Shared types and constants for the fpu register block and its command sequencer.
package pa_fpu;

    typedef enum logic [1:0] {
        FPU_OP_ADD = 2'd0,
        FPU_OP_SUB = 2'd1,
        FPU_OP_MUL = 2'd2,
        FPU_OP_DIV = 2'd3
    } e_fpu_op;

    // fpu register map
    localparam logic [3:0] FPU_ADDR_A0    = 4'd0;
    localparam logic [3:0] FPU_ADDR_B0    = 4'd4;
    localparam logic [3:0] FPU_ADDR_OP    = 4'd8;
    localparam logic [3:0] FPU_ADDR_START = 4'd9;
    localparam logic [3:0] FPU_ADDR_RES0  = 4'd9;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_WRITE    = 3'd1,
        SEQ_WAIT_END = 3'd2,
        SEQ_READ     = 3'd3,
        SEQ_ACK      = 3'd4,
        SEQ_RESP     = 3'd5
    } e_fpu_seq_state;

    // Read-phase step index: 0 setup, 1..4 byte slots, 5 trailing cycle
    localparam logic [3:0] RD_IDX_SETUP     = 4'd0;
    localparam logic [3:0] RD_IDX_LAST_SLOT = 4'd4;
    localparam logic [3:0] RD_IDX_TRAIL     = 4'd5;

    // Bus transfer phases
    localparam logic [1:0] XFER_WR_STROBE_PH = 2'd1;
    localparam logic [1:0] XFER_WR_LAST_PH   = 2'd2;
    localparam logic [1:0] XFER_RD_LAST_PH   = 2'd1;

endpackage

// File: rtl/fpu_bus_xfer.sv
// Single fpu bus slot: 3-cycle write (setup/strobe/hold) or 2-cycle read strobe.
// A new slot may be started while idle or in the last cycle of the current one.
module fpu_bus_xfer
    import pa_fpu::*;
(
    input  logic clk,
    input  logic arst_n,
    input  logic start,
    input  logic rd_req,
    output logic done,
    output logic wr_n,
    output logic rd_n
);

    logic       active;
    logic       is_rd;
    logic [1:0] phase;

    // Phase counter for the slot in progress
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            active <= 1'b0;
            is_rd  <= 1'b0;
            phase  <= 2'd0;
        end else if (start) begin
            active <= 1'b1;
            is_rd  <= rd_req;
            phase  <= 2'd0;
        end else if (done) begin
            active <= 1'b0;
        end else if (active) begin
            phase <= phase + 2'd1;
        end
    end

    // Strobe and completion decode
    always_comb begin
        done = active && (phase == (is_rd ? XFER_RD_LAST_PH : XFER_WR_LAST_PH));
        wr_n = !(active && !is_rd && (phase == XFER_WR_STROBE_PH));
        rd_n = !(active && is_rd);
    end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Bus-master front end for the fpu: writes operands/op/start, waits for
// completion (with timeout), reads the result and returns it on a response port.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// SEQ_IDLE     | ready for a command; drains any stale cmd_end with end_ack
// SEQ_WRITE    | 10 byte writes: A[0..3], B[0..3], op, start
// SEQ_WAIT_END | waiting for cmd_end, timeout counter running
// SEQ_READ     | setup, 4 read slots at addr 9..12, trailing cycle
// SEQ_ACK      | end_ack high until cmd_end drops
// SEQ_RESP     | rsp_valid high until rsp_ready
module fpu_cmd_sequencer
    import pa_fpu::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  e_fpu_op     req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic [7:0]  fpu_data_wr,
    input  logic [7:0]  fpu_data_rd,
    output logic [3:0]  fpu_addr,
    output logic        fpu_cs,
    output logic        fpu_rd,
    output logic        fpu_wr,
    output logic        fpu_end_ack,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    e_fpu_seq_state  state, state_d;
    logic [3:0]      idx;
    logic [3:0]      rd_ofs;
    logic [TO_W-1:0] to_cnt;
    e_fpu_op         op_q;
    logic [31:0]     a_q, b_q;
    logic            ack_q;
    logic            accept;
    logic            xfer_start, xfer_rd, xfer_done;

    assign req_ready   = (state == SEQ_IDLE) && !fpu_busy && !fpu_cmd_end;
    assign accept      = req_valid && req_ready;
    assign fpu_end_ack = ack_q;

    fpu_bus_xfer u_xfer (
        .clk    (clk),
        .arst_n (arst_n),
        .start  (xfer_start),
        .rd_req (xfer_rd),
        .done   (xfer_done),
        .wr_n   (fpu_wr),
        .rd_n   (fpu_rd)
    );

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= SEQ_IDLE;
        else         state <= state_d;
    end

    // Next state and bus-slot requests
    always_comb begin
        state_d    = state;
        xfer_start = 1'b0;
        xfer_rd    = 1'b0;
        unique case (state)
            SEQ_IDLE: begin
                if (accept) begin
                    state_d    = SEQ_WRITE;
                    xfer_start = 1'b1;
                end
            end
            SEQ_WRITE: begin
                if (xfer_done) begin
                    if (idx == FPU_ADDR_START) state_d    = SEQ_WAIT_END;
                    else                       xfer_start = 1'b1;
                end
            end
            SEQ_WAIT_END: begin
                // completion wins over a timeout landing in the same cycle
                if (fpu_cmd_end)           state_d = SEQ_READ;
                else if (to_cnt == TO_LAST) state_d = SEQ_RESP;
            end
            SEQ_READ: begin
                xfer_rd = 1'b1;
                if (idx == RD_IDX_SETUP)                         xfer_start = 1'b1;
                else if (idx == RD_IDX_TRAIL)                    state_d    = SEQ_ACK;
                else if (xfer_done && idx != RD_IDX_LAST_SLOT)   xfer_start = 1'b1;
            end
            SEQ_ACK: begin
                if (!fpu_cmd_end) state_d = SEQ_RESP;
            end
            SEQ_RESP: begin
                if (rsp_ready) state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Command latch, step index, timeout counter, ack and response registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            op_q        <= FPU_OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
            to_cnt      <= '0;
            ack_q       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_result  <= '0;
        end else begin
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (state_d != state)
                idx <= '0;
            else if ((state == SEQ_WRITE && xfer_done) ||
                     (state == SEQ_READ && (idx == RD_IDX_SETUP || xfer_done)))
                idx <= idx + 4'd1;
            to_cnt <= (state == SEQ_WAIT_END) ? to_cnt + TO_W'(1) : '0;
            ack_q  <= (state_d == SEQ_ACK) || (state == SEQ_IDLE && fpu_cmd_end);
            // bytes arrive LSB first; after four shifts byte 0 sits in [7:0]
            if (state == SEQ_READ && xfer_done)
                rsp_result <= {fpu_data_rd, rsp_result[31:8]};
            if (state == SEQ_WAIT_END && state_d == SEQ_RESP) begin
                rsp_valid   <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_result  <= '0;
            end
            if (state == SEQ_ACK && state_d == SEQ_RESP) begin
                rsp_valid   <= 1'b1;
                rsp_timeout <= 1'b0;
            end
            if (state == SEQ_RESP && rsp_ready) begin
                rsp_valid   <= 1'b0;
                rsp_timeout <= 1'b0;
            end
        end
    end

    // Bus address/data decode from the current step
    always_comb begin
        fpu_cs      = 1'b1;
        fpu_addr    = '0;
        fpu_data_wr = '0;
        rd_ofs      = '0;
        case (state)
            SEQ_WRITE: begin
                fpu_cs   = 1'b0;
                fpu_addr = idx;
                if (idx < FPU_ADDR_B0)
                    fpu_data_wr = a_q[{idx[1:0], 3'b000} +: 8];
                else if (idx < FPU_ADDR_OP)
                    fpu_data_wr = b_q[{idx[1:0], 3'b000} +: 8];
                else if (idx == FPU_ADDR_OP)
                    fpu_data_wr = {{(8 - $bits(e_fpu_op)){1'b0}}, op_q};
            end
            SEQ_READ: begin
                fpu_cs = 1'b0;
                if (idx == RD_IDX_SETUP)      rd_ofs = 4'd0;
                else if (idx >= RD_IDX_TRAIL) rd_ofs = 4'd3;
                else                          rd_ofs = idx - 4'd1;
                fpu_addr = FPU_ADDR_RES0 + rd_ofs;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed bench for fpu_cmd_sequencer with a behavioural fpu bus model.
module tb_fpu_cmd_sequencer;
    import pa_fpu::*;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    e_fpu_op     req_op = FPU_OP_ADD;
    logic [31:0] req_a = '0, req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic [7:0]  fpu_data_wr, fpu_data_rd;
    logic [3:0]  fpu_addr;
    logic        fpu_cs, fpu_rd, fpu_wr, fpu_end_ack, fpu_cmd_end, fpu_busy;

    int nvec = 0;
    int nfail = 0;

    // fpu model state
    logic        m_busy, m_end;
    logic        tb_cmd_end = 1'b0;
    logic        m_hang = 1'b0;
    int          m_lat = 3;
    int          m_cnt;
    logic [31:0] m_result = '0;
    logic [11:0] wlog[$];

    always #5 clk = ~clk;

    fpu_cmd_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .fpu_data_wr (fpu_data_wr),
        .fpu_data_rd (fpu_data_rd),
        .fpu_addr    (fpu_addr),
        .fpu_cs      (fpu_cs),
        .fpu_rd      (fpu_rd),
        .fpu_wr      (fpu_wr),
        .fpu_end_ack (fpu_end_ack),
        .fpu_cmd_end (fpu_cmd_end),
        .fpu_busy    (fpu_busy)
    );

    function automatic logic [7:0] res_byte(input logic [3:0] a, input logic [31:0] r);
        case (a)
            4'd9:    return r[7:0];
            4'd10:   return r[15:8];
            4'd11:   return r[23:16];
            4'd12:   return r[31:24];
            default: return 8'h00;
        endcase
    endfunction

    assign fpu_busy    = m_busy;
    assign fpu_cmd_end = m_end | tb_cmd_end;
    assign fpu_data_rd = (!fpu_cs && !fpu_rd) ? res_byte(fpu_addr, m_result) : 8'h00;

    // fpu model: logs writes, starts on a write to addr 9, raises cmd_end m_lat+1 cycles later
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_busy <= 1'b0;
            m_end  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (!fpu_cs && !fpu_wr) begin
                wlog.push_back({fpu_addr, fpu_data_wr});
                if (fpu_addr == FPU_ADDR_START && !m_busy) begin
                    m_busy <= 1'b1;
                    m_cnt  <= m_lat;
                end
            end
            if (m_busy && !m_hang) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_end  <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (m_end && fpu_end_ack) m_end <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer a request and return just after the accepting edge
    task automatic send(input e_fpu_op op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        chk("accept_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count cycles from the accepting edge until rsp_valid is seen
    task automatic wait_rsp(output int n);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic early;
        logic [11:0] exp1 [10];
        exp1 = '{12'h0ff, 12'h1ff, 12'h2ff, 12'h33f, 12'h400,
                 12'h500, 12'h680, 12'h73f, 12'h802, 12'h900};

        // reset values
        #12;
        chk("rst_cs", fpu_cs, 1);
        chk("rst_wr", fpu_wr, 1);
        chk("rst_rd", fpu_rd, 1);
        chk("rst_addr", fpu_addr, 0);
        chk("rst_data", fpu_data_wr, 0);
        chk("rst_ack", fpu_end_ack, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_rsp_result", rsp_result, 0);
        @(negedge clk) arst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);

        // mul 0x3fffffff * 1.0
        m_result = 32'h3fffffff; m_lat = 3; wlog.delete();
        send(FPU_OP_MUL, 32'h3fffffff, 32'h3f800000);
        wait_rsp(n);
        chk("t1_latency", n, 47);
        chk("t1_result", rsp_result, 32'h3fffffff);
        chk("t1_timeout", rsp_timeout, 0);
        chk("t1_wr_count", wlog.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("t1_wr%0d", i), wlog[i], exp1[i]);
        handshake();
        chk("t1_ready_after", req_ready, 1);

        // back-to-back: second request held valid throughout the first
        m_result = 32'h41a00000; m_lat = 3;
        send(FPU_OP_MUL, 32'h40000000, 32'h41200000);
        req_op = FPU_OP_ADD; req_a = 32'h3f800000; req_b = 32'h40400000; req_valid = 1'b1;
        early = 1'b0;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready) early = 1'b1;
            if (rsp_valid) break;
        end
        chk("t2_no_early_ready", early, 0);
        chk("t2_latency", n, 47);
        chk("t2_result", rsp_result, 32'h41a00000);
        m_result = 32'h40800000; wlog.delete();
        chk("t2_ready_in_resp", req_ready, 0);
        handshake();
        chk("t2_ready_next", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(n);
        chk("t2b_latency", n, 47);
        chk("t2b_result", rsp_result, 32'h40800000);
        chk("t2b_wr0", wlog[0], 12'h000);
        chk("t2b_wr3", wlog[3], 12'h33f);
        chk("t2b_wr7", wlog[7], 12'h740);
        chk("t2b_wr8", wlog[8], 12'h800);
        handshake();

        // back-pressure with a longer fpu latency
        m_result = 32'hc0490fdb; m_lat = 10;
        send(FPU_OP_DIV, 32'h40490fdb, 32'hbf800000);
        wait_rsp(n);
        chk("t3_latency", n, 54);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_valid_hold", rsp_valid, 1);
            chk("t3_result_hold", rsp_result, 32'hc0490fdb);
            chk("t3_timeout_hold", rsp_timeout, 0);
            chk("t3_req_ready_low", req_ready, 0);
        end
        handshake();

        // timeout: fpu never completes
        m_hang = 1'b1;
        send(FPU_OP_MUL, 32'h3f800000, 32'h3f800000);
        wait_rsp(n);
        chk("t4_latency", n, 95);
        chk("t4_timeout", rsp_timeout, 1);
        chk("t4_result", rsp_result, 0);
        chk("t4_no_ack", fpu_end_ack, 0);
        handshake();
        chk("t4_timeout_clr", rsp_timeout, 0);
        chk("t4_ready_busy", req_ready, 0);
        tb_cmd_end = 1'b1;
        @(negedge clk);
        chk("t4_late_ack", fpu_end_ack, 1);
        chk("t4_late_ready", req_ready, 0);
        tb_cmd_end = 1'b0;
        @(negedge clk);
        chk("t4_late_ack_drop", fpu_end_ack, 0);

        // reset during the B-byte writes
        arst_n = 1'b0; m_hang = 1'b0;
        @(negedge clk) arst_n = 1'b1;
        m_lat = 3;
        send(FPU_OP_SUB, 32'h12345678, 32'h9abcdef0);
        repeat (14) @(negedge clk);
        chk("t5_strobe_b0", fpu_wr, 0);
        chk("t5_addr_b0", fpu_addr, 4);
        chk("t5_data_b0", fpu_data_wr, 8'hf0);
        arst_n = 1'b0;
        #1;
        chk("t5_cs", fpu_cs, 1);
        chk("t5_wr", fpu_wr, 1);
        chk("t5_rd", fpu_rd, 1);
        chk("t5_addr", fpu_addr, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        @(negedge clk) arst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready", req_ready, 1);
        chk("t5_cs_idle", fpu_cs, 1);
        m_result = 32'h40800000; wlog.delete();
        send(FPU_OP_MUL, 32'h40000000, 32'h40000000);
        wait_rsp(n);
        chk("t5b_latency", n, 47);
        chk("t5b_result", rsp_result, 32'h40800000);
        chk("t5b_wr7", wlog[7], 12'h740);
        handshake();

        // stale completion present at reset release
        @(negedge clk);
        arst_n = 1'b0; tb_cmd_end = 1'b1;
        #1;
        chk("t6_ack_in_reset", fpu_end_ack, 0);
        @(negedge clk) arst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_ack_high", fpu_end_ack, 1);
            chk("t6_ready_low", req_ready, 0);
        end
        tb_cmd_end = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", req_ready, 1);
        chk("t6_ack_after", fpu_end_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
